// File: rtl/simon_pkg.sv
// Shared SIMON constants: z sequences, round counts, z selection and the key-stream state enum.
// The SIMON round engine uses this package as well.
package simon_pkg;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  function automatic logic [61:0] rev62(input logic [61:0] x);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = x[61-i];
    return r;
  endfunction

  // Literals are written in paper digit order (first digit leftmost), then flipped so bit i = digit i
  localparam logic [61:0] Z0 = rev62(62'b11111010001001010110000111001101111101000100101011000011100110);
  localparam logic [61:0] Z1 = rev62(62'b10001110111110010011000010110101000111011111001001100001011010);
  localparam logic [61:0] Z2 = rev62(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [61:0] Z3 = rev62(62'b11011011101011000110010111100000010010001010011100110100001111);
  localparam logic [61:0] Z4 = rev62(62'b11010001111001101011011000100000010111000011001010010011101111);

  function automatic int rounds(input int n, input int m);
    if (n == 16)      return 32;
    else if (n == 24) return 36;
    else if (n == 32) return (m == 3) ? 42 : 44;
    else if (n == 48) return (m == 2) ? 52 : 54;
    else              return (m == 2) ? 68 : ((m == 3) ? 69 : 72);
  endfunction

  function automatic int zsel(input int n, input int m);
    if (n == 16)      return 0;
    else if (n == 24) return (m == 3) ? 0 : 1;
    else if (n == 32) return (m == 3) ? 2 : 3;
    else if (n == 48) return (m == 2) ? 2 : 3;
    else              return (m == 2) ? 2 : ((m == 3) ? 3 : 4);
  endfunction

  function automatic logic [61:0] zseq(input int j);
    case (j)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One SIMON key-schedule step: window of M words plus z bit -> next key word.
module simon_key_step #(
  parameter int N = 64,
  parameter int M = 4
) (
  input  logic [M*N-1:0] win,
  input  logic           zbit,
  output logic [N-1:0]   next
);
  logic [N-1:0] w0, wl, t0, t1;

  assign w0 = win[N-1:0];
  assign wl = win[M*N-1:(M-1)*N];

  generate
    if (M == 4) begin : g_m4
      assign t0 = {wl[2:0], wl[N-1:3]} ^ win[2*N-1:N];
    end else begin : g_mx
      assign t0 = {wl[2:0], wl[N-1:3]};
    end
  endgenerate

  assign t1 = t0 ^ {t0[0], t0[N-1:1]};
  // ~w0 ^ 3 is the constant c = 2^N-4 folded into the XOR chain
  assign next = ~w0 ^ t1 ^ {{(N-2){1'b0}}, 2'b11} ^ {{(N-1){1'b0}}, zbit};
endmodule

// File: rtl/simon_key_stream.sv
// SIMON key expansion engine: loads an M-word master key and streams T round keys
// over a valid/ready handshake, one per accepted beat.
module simon_key_stream
  import simon_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           res,
  input  logic           start,
  input  logic [M*N-1:0] key,
  output logic           busy,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk_data,
  output logic [6:0]     rk_idx,
  output logic           done
);
  localparam int          T  = rounds(N, M);
  localparam logic [61:0] ZV = zseq(zsel(N, M));

  state_t               state;
  logic [M-1:0][N-1:0]  win;
  logic [5:0]           zcnt;
  logic [N-1:0]         nxt;

  simon_key_step #(.N(N), .M(M)) u_step (
    .win  (win),
    .zbit (ZV[zcnt]),
    .next (nxt)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= S_IDLE;
      win      <= '0;
      zcnt     <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            win      <= key;
            zcnt     <= '0;
            rk_idx   <= '0;
            rk_data  <= key[N-1:0];
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          // rk_valid is always high here, so ready alone marks an accept
          if (rk_ready) begin
            win  <= {nxt, win[M-1:1]};
            zcnt <= (zcnt == 6'd61) ? 6'd0 : zcnt + 6'd1;
            if (rk_idx == 7'(T-1)) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              rk_idx  <= rk_idx + 7'd1;
              rk_data <= win[1];
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_key_stream.sv
// Bench for simon_key_stream: four configurations checked against a word-level key schedule model.
module tb_simon_key_stream;
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic         start_v [4];
  logic [255:0] key_v   [4];
  logic         rdy_v   [4];
  logic         busy_v  [4];
  logic         val_v   [4];
  logic         done_v  [4];
  logic [63:0]  dat_v   [4];
  logic [6:0]   idx_v   [4];

  logic [15:0] d0;
  logic [63:0] d1, d2;
  logic [47:0] d3;
  assign dat_v[0] = {48'd0, d0};
  assign dat_v[1] = d1;
  assign dat_v[2] = d2;
  assign dat_v[3] = {16'd0, d3};

  simon_key_stream #(.N(16), .M(4)) u0 (.clk(clk), .res(res), .start(start_v[0]), .key(key_v[0][63:0]),
    .busy(busy_v[0]), .rk_valid(val_v[0]), .rk_ready(rdy_v[0]), .rk_data(d0), .rk_idx(idx_v[0]), .done(done_v[0]));
  simon_key_stream #(.N(64), .M(4)) u1 (.clk(clk), .res(res), .start(start_v[1]), .key(key_v[1][255:0]),
    .busy(busy_v[1]), .rk_valid(val_v[1]), .rk_ready(rdy_v[1]), .rk_data(d1), .rk_idx(idx_v[1]), .done(done_v[1]));
  simon_key_stream #(.N(64), .M(2)) u2 (.clk(clk), .res(res), .start(start_v[2]), .key(key_v[2][127:0]),
    .busy(busy_v[2]), .rk_valid(val_v[2]), .rk_ready(rdy_v[2]), .rk_data(d2), .rk_idx(idx_v[2]), .done(done_v[2]));
  simon_key_stream #(.N(48), .M(3)) u3 (.clk(clk), .res(res), .start(start_v[3]), .key(key_v[3][143:0]),
    .busy(busy_v[3]), .rk_valid(val_v[3]), .rk_ready(rdy_v[3]), .rk_data(d3), .rk_idx(idx_v[3]), .done(done_v[3]));

  int checks = 0;
  int errors = 0;

  string zs [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"};

  logic [63:0] exp_ks [72];
  logic [63:0] obs    [72];
  int          tn;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic int tb_rounds(input int n, input int m);
    case (n)
      16: return 32;
      24: return 36;
      32: return (m == 3) ? 42 : 44;
      48: return (m == 2) ? 52 : 54;
      default: return 66 + m + ((m == 4) ? 2 : (m == 3) ? 0 : 0);
    endcase
  endfunction

  function automatic int tb_zsel(input int n, input int m);
    case (n)
      16: return 0;
      24: return m - 3;
      32: return m - 1;
      default: return m;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n, input logic [63:0] mask);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Key schedule straight from the cipher definition, on plain words mod 2^n
  task automatic gen(input int n, input int m, input logic [255:0] k);
    logic [63:0] mask, tmp, zb;
    int j;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    tn = tb_rounds(n, m);
    j  = tb_zsel(n, m);
    for (int i = 0; i < m; i++) exp_ks[i] = 64'(k >> (i * n)) & mask;
    for (int i = m; i < tn; i++) begin
      tmp = ror(exp_ks[i-1], 3, n, mask);
      if (m == 4) tmp = tmp ^ exp_ks[i-3];
      tmp = tmp ^ ror(tmp, 1, n, mask);
      zb  = (zs[j][(i - m) % 62] == "1") ? 64'd1 : 64'd0;
      exp_ks[i] = (~exp_ks[i-m] & mask) ^ tmp ^ 64'd3 ^ zb;
    end
  endtask

  // mode 1: random ready with occasional 20-cycle stalls; inject_at: foreign start at that beat;
  // res_at: pulse reset at that beat and abandon the stream
  task automatic run(input int u, input int n, input int m, input logic [255:0] k, input int mode,
                     input int inject_at, input int res_at, input string tag);
    int beats, cyc, stall;
    bit inj, rdy;
    gen(n, m, k);
    @(negedge clk);
    start_v[u] = 1'b1; key_v[u] = k;
    @(negedge clk);
    start_v[u] = 1'b0; key_v[u] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy"}, 64'(busy_v[u]), 64'd1);
    beats = 0; cyc = 0; stall = 0; inj = 0;
    while (beats < tn && cyc < 4000) begin
      cyc++;
      if (res_at >= 0 && beats == res_at) begin
        rdy_v[u] = 1'b0; res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk({tag, "_rst_val"},  64'(val_v[u]),  64'd0);
        chk({tag, "_rst_busy"}, 64'(busy_v[u]), 64'd0);
        chk({tag, "_rst_data"}, dat_v[u],       64'd0);
        chk({tag, "_rst_idx"},  64'(idx_v[u]),  64'd0);
        for (int c = 0; c < 3; c++) begin
          chk({tag, "_rst_done"}, 64'(done_v[u]), 64'd0);
          @(negedge clk);
        end
        return;
      end
      chk({tag, "_valid"}, 64'(val_v[u]),  64'd1);
      chk({tag, "_data"},  dat_v[u],       exp_ks[beats]);
      chk({tag, "_idx"},   64'(idx_v[u]),  64'(beats));
      chk({tag, "_done"},  64'(done_v[u]), 64'd0);
      obs[beats] = dat_v[u];
      if (mode == 0) rdy = 1'b1;
      else if (stall > 0) begin rdy = 1'b0; stall--; end
      else begin
        int r = int'($urandom_range(0, 15));
        if (r == 0) stall = 20;
        rdy = (r > 5);
      end
      rdy_v[u] = rdy;
      if (inject_at == beats && !inj) begin
        start_v[u] = 1'b1; key_v[u] = ~k; inj = 1'b1;
      end else start_v[u] = 1'b0;
      if (rdy) beats++;
      @(negedge clk);
    end
    rdy_v[u] = 1'b0; start_v[u] = 1'b0;
    chk({tag, "_count"},     64'(beats),     64'(tn));
    chk({tag, "_done_hi"},   64'(done_v[u]), 64'd1);
    chk({tag, "_done_val"},  64'(val_v[u]),  64'd0);
    chk({tag, "_done_busy"}, 64'(busy_v[u]), 64'd0);
    chk({tag, "_last_data"}, dat_v[u],       exp_ks[tn-1]);
    chk({tag, "_last_idx"},  64'(idx_v[u]),  64'(tn - 1));
    @(negedge clk);
    chk({tag, "_done_lo"},   64'(done_v[u]), 64'd0);
  endtask

  localparam logic [255:0] K1 = 256'h1918_1110_0908_0100;

  initial begin
    for (int u = 0; u < 4; u++) begin start_v[u] = 1'b0; key_v[u] = '0; rdy_v[u] = 1'b0; end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk("reset_busy", 64'(busy_v[u]), 64'd0);
      chk("reset_val",  64'(val_v[u]),  64'd0);
      chk("reset_data", dat_v[u],       64'd0);
      chk("reset_idx",  64'(idx_v[u]),  64'd0);
      chk("reset_done", 64'(done_v[u]), 64'd0);
    end
    res = 1'b0;

    run(0, 16, 4, K1, 0, -1, -1, "t1");
    chk("t1_b0", obs[0], 64'h0100);
    chk("t1_b3", obs[3], 64'h1918);
    chk("t1_b4", obs[4], 64'h71c3);
    chk("t1_b5", obs[5], 64'hb649);

    run(0, 16, 4, K1, 1, -1, -1, "t2");
    chk("t2_b5", obs[5], 64'hb649);

    run(1, 64, 4, 256'd0, 0, -1, -1, "t3");
    chk("t3_b71", obs[71], 64'h1A87AFF74EDE4B2A);

    run(2, 64, 2, {$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, "t4a");
    run(3, 48, 3, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1, -1, -1, "t4b");

    run(0, 16, 4, K1, 1, 10, -1, "t5");
    run(0, 16, 4, K1, 0, -1, 7, "t6_abort");
    run(0, 16, 4, K1, 0, -1, -1, "t6_restart");
    run(0, 16, 4, {$urandom, $urandom}, 1, -1, -1, "rnd16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
